// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial link
// Purpose: FSM state encoding, SC bit positions and default register addresses.
// Ports: none (package).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } serial_state_t;

  localparam int SC_START = 7;
  localparam int SC_SPEED = 1;
  localparam int SC_SRC   = 0;

  localparam logic [15:0] SB_ADDR_DEFAULT = 16'hFF01;
  localparam logic [15:0] SC_ADDR_DEFAULT = 16'hFF02;

endpackage

// File: rtl/serial_sync_edge.sv
// rtl/serial_sync_edge.sv - two-flop synchroniser with rise/fall pulses
// Purpose: bring an asynchronous clock-like input into I_CLK and flag its edges.
// Ports:
//   I_CLK    system clock
//   I_RESET  synchronous active-high reset (flops preset to 1, the idle level)
//   i_async  asynchronous input
//   o_rise   one-cycle pulse on a synchronised 0->1 transition
//   o_fall   one-cycle pulse on a synchronised 1->0 transition
module serial_sync_edge (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/serial_link.sv
// rtl/serial_link.sv - memory-mapped SB/SC serial shift link
// Purpose: CPU-visible SB (data) and SC (control) registers driving an MSB-first
//   shift link clocked internally (normal/fast divider) or by an external clock.
// Ports:
//   I_CLK, I_RESET         system clock, synchronous active-high reset
//   I_ADDR_BUS             CPU address
//   IO_DATA_BUS            CPU write data
//   I_WE_BUS_L, I_RE_BUS_L write/read strobes, active low
//   O_DATA_BUS, O_DATA_OE  read data and its enable
//   O_SERIAL_INTERRUPT     one-cycle pulse when a transfer completes
//   I_EXTERNAL_CLOCK       asynchronous external serial clock
//   O_SERIAL_CLOCK         generated serial clock, idles high
//   I_SERIAL_DATA          asynchronous serial input
//   O_SERIAL_DATA          serial output bit
module serial_link
  import serial_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          DIV_NORMAL = 512,
  parameter int          DIV_FAST   = 16,
  parameter logic [15:0] SB_ADDR    = SB_ADDR_DEFAULT,
  parameter logic [15:0] SC_ADDR    = SC_ADDR_DEFAULT
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_ADDR_BUS,
  input  logic [7:0]  IO_DATA_BUS,
  input  logic        I_WE_BUS_L,
  input  logic        I_RE_BUS_L,
  output logic [7:0]  O_DATA_BUS,
  output logic        O_DATA_OE,
  output logic        O_SERIAL_INTERRUPT,
  input  logic        I_EXTERNAL_CLOCK,
  output logic        O_SERIAL_CLOCK,
  input  logic        I_SERIAL_DATA,
  output logic        O_SERIAL_DATA
);

  localparam int DIV_MAX = (DIV_NORMAL > DIV_FAST) ? DIV_NORMAL : DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX);
  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] HALF_NORMAL = DIV_W'(DIV_NORMAL / 2);
  localparam logic [DIV_W-1:0] HALF_FAST   = DIV_W'(DIV_FAST / 2);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(DATA_WIDTH);

  serial_state_t r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sb, w_sb_nxt, w_sb_wr;
  logic [7:0]            w_sb_rd;
  logic r_sc_start, w_sc_start_nxt;
  logic r_sc_speed, w_sc_speed_nxt;
  logic r_sc_src,   w_sc_src_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nxt;
  logic [DIV_W-1:0] r_half,    w_half_nxt;
  logic r_sclk, w_sclk_nxt;
  logic r_sout, w_sout_nxt;
  logic r_irq,  w_irq_nxt;
  logic r_sin_meta, r_sin_sync;

  logic w_ext_rise, w_ext_fall;
  logic w_sb_hit, w_sc_hit, w_sb_we, w_sc_we;
  logic w_half_done, w_low_end, w_high_end;

  serial_sync_edge u_ext_clk_sync (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .i_async (I_EXTERNAL_CLOCK),
    .o_rise  (w_ext_rise),
    .o_fall  (w_ext_fall)
  );

  // Serial data only needs to be stable when a clock edge is detected.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_sin_meta <= 1'b1;
      r_sin_sync <= 1'b1;
    end else begin
      r_sin_meta <= I_SERIAL_DATA;
      r_sin_sync <= r_sin_meta;
    end
  end

  // The CPU sees the top byte of SB; narrower links are zero-extended.
  generate
    if (DATA_WIDTH >= 8) begin : g_sb_wide
      assign w_sb_rd = r_sb[DATA_WIDTH-1 -: 8];
      assign w_sb_wr = DATA_WIDTH'(IO_DATA_BUS) << (DATA_WIDTH - 8);
    end else begin : g_sb_narrow
      assign w_sb_rd = 8'(r_sb);
      assign w_sb_wr = IO_DATA_BUS[DATA_WIDTH-1:0];
    end
  endgenerate

  assign w_sb_hit = (I_ADDR_BUS == SB_ADDR);
  assign w_sc_hit = (I_ADDR_BUS == SC_ADDR);
  assign w_sb_we  = ~I_WE_BUS_L & w_sb_hit;
  assign w_sc_we  = ~I_WE_BUS_L & w_sc_hit;

  always_comb begin
    O_DATA_OE  = 1'b0;
    O_DATA_BUS = 8'h00;
    if (!I_RE_BUS_L) begin
      if (w_sb_hit) begin
        O_DATA_OE  = 1'b1;
        O_DATA_BUS = w_sb_rd;
      end else if (w_sc_hit) begin
        O_DATA_OE  = 1'b1;
        O_DATA_BUS = {r_sc_start, 5'b11111, r_sc_speed, r_sc_src};
      end
    end
  end

  assign w_half_done = (r_div_cnt == r_half - DIV_W'(1));
  assign w_low_end   = r_sc_src ? w_half_done : w_ext_rise;
  assign w_high_end  = r_sc_src ? w_half_done : w_ext_fall;

  always_comb begin
    w_state_nxt    = r_state;
    w_sb_nxt       = r_sb;
    w_sc_start_nxt = r_sc_start;
    w_sc_speed_nxt = r_sc_speed;
    w_sc_src_nxt   = r_sc_src;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_div_cnt_nxt  = r_div_cnt;
    w_half_nxt     = r_half;
    w_sclk_nxt     = r_sclk;
    w_sout_nxt     = r_sout;
    w_irq_nxt      = 1'b0;

    if (w_sb_we && !r_sc_start) begin
      w_sb_nxt = w_sb_wr;
    end

    case (r_state)
      IDLE: begin
      end
      LOW: begin
        if (w_low_end) begin
          // Rising serial clock: sample the input into the LSB.
          w_state_nxt   = HIGH;
          w_div_cnt_nxt = '0;
          w_sclk_nxt    = 1'b1;
          w_sb_nxt      = {r_sb[DATA_WIDTH-2:0], r_sin_sync};
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end else if (r_sc_src) begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      HIGH: begin
        if (w_high_end) begin
          w_div_cnt_nxt = '0;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = LOW;
            w_sclk_nxt  = 1'b0;
            w_sout_nxt  = r_sb[DATA_WIDTH-1];
          end
        end else if (r_sc_src) begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      DONE: begin
        w_state_nxt    = IDLE;
        w_sc_start_nxt = 1'b0;
        w_irq_nxt      = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A CPU SC write overrides whatever the FSM decided this cycle,
    // including suppressing the completion pulse in DONE.
    if (w_sc_we) begin
      w_sc_start_nxt = IO_DATA_BUS[SC_START];
      w_sc_speed_nxt = IO_DATA_BUS[SC_SPEED];
      w_sc_src_nxt   = IO_DATA_BUS[SC_SRC];
      if (IO_DATA_BUS[SC_START]) begin
        w_state_nxt   = LOW;
        w_sb_nxt      = r_sb;
        w_bit_cnt_nxt = '0;
        w_div_cnt_nxt = '0;
        w_half_nxt    = IO_DATA_BUS[SC_SPEED] ? HALF_FAST : HALF_NORMAL;
        w_sclk_nxt    = 1'b0;
        w_sout_nxt    = r_sb[DATA_WIDTH-1];
        w_irq_nxt     = 1'b0;
      end else if (r_sc_start) begin
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
        w_div_cnt_nxt = '0;
        w_sclk_nxt    = 1'b1;
        w_irq_nxt     = 1'b0;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state    <= IDLE;
      r_sb       <= '0;
      r_sc_start <= 1'b0;
      r_sc_speed <= 1'b0;
      r_sc_src   <= 1'b0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_half     <= HALF_NORMAL;
      r_sclk     <= 1'b1;
      r_sout     <= 1'b1;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sb       <= w_sb_nxt;
      r_sc_start <= w_sc_start_nxt;
      r_sc_speed <= w_sc_speed_nxt;
      r_sc_src   <= w_sc_src_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_half     <= w_half_nxt;
      r_sclk     <= w_sclk_nxt;
      r_sout     <= w_sout_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  assign O_SERIAL_CLOCK     = r_sclk;
  assign O_SERIAL_DATA      = r_sout;
  assign O_SERIAL_INTERRUPT = r_irq;

endmodule

// File: doc/serial_link.md
Name: serial_link

Overview:
- Parametrised successor to the GBC serial port (SB/SC).
- Memory-mapped shift-register link with internal or external clock and CGB normal/fast internal speed selected by SC[1].
- Proper clock edge detection, MSB-first shift, a read-back path, abort/restart, and a one-cycle interrupt pulse to the interrupt controller.
- Sits on the CPU I/O bus beside the timer and joypad blocks.

Parameters:
- DATA_WIDTH, 8: shift register width; bits per transfer.
- DIV_NORMAL, 512: I_CLK cycles per serial bit in normal speed (8192 Hz at 4.19 MHz); must be even, >=4.
- DIV_FAST, 16: I_CLK cycles per serial bit in fast speed (SC[1]=1); must be even, >=4.
- SB_ADDR, 16'hFF01: data register address.
- SC_ADDR, 16'hFF02: control register address.

Ports:
- I_CLK  in  1  system clock.
- I_RESET  in  1  synchronous, active-high reset.
- I_ADDR_BUS  in  16  CPU address.
- IO_DATA_BUS  in  8  CPU write data.
- I_WE_BUS_L  in  1  write strobe, active low.
- I_RE_BUS_L  in  1  read strobe, active low.
- O_DATA_BUS  out  8  read data; valid when O_DATA_OE=1.
- O_DATA_OE  out  1  high when a read hits SB_ADDR or SC_ADDR.
- O_SERIAL_INTERRUPT  out  1  one-cycle pulse on transfer completion.
- I_EXTERNAL_CLOCK  in  1  asynchronous external serial clock.
- O_SERIAL_CLOCK  out  1  generated serial clock; idles high.
- I_SERIAL_DATA  in  1  asynchronous serial input.
- O_SERIAL_DATA  out  1  serial output bit.

Behaviour:
- Reset: SB=0, SC=0, state IDLE, bit counter 0, O_SERIAL_CLOCK=1, O_SERIAL_DATA=1, O_SERIAL_INTERRUPT=0. Reset mid-transfer aborts immediately, no interrupt.
- SC fields: [7] start/busy, [1] speed (0 normal, 1 fast), [0] source (1 internal, 0 external). Other bits read as 1.
- Reads are combinational when ~I_RE_BUS_L and the address matches: SB returns SB[DATA_WIDTH-1 -: 8] zero-extended/truncated; SC returns {SC[7],5'b11111,SC[1],SC[0]}. O_DATA_OE=0 and O_DATA_BUS=0 otherwise.
- Writes take effect on the I_CLK edge where I_WE_BUS_L=0 and the address matches.
- SB writes while busy (SC[7]=1) are ignored.
- SC write with bit7=1 in IDLE starts a transfer. Counter clears, O_SERIAL_DATA <= SB MSB the same edge, state goes to LOW.
- SC write with bit7=1 while busy restarts: counter=0, state LOW, SB keeps its partially shifted contents.
- SC write with bit7=0 while busy aborts: state IDLE, O_SERIAL_CLOCK=1, no interrupt.
- External sync: I_EXTERNAL_CLOCK and I_SERIAL_DATA each pass a 2-flop synchroniser; external clock edges are detected on the synchronised value.
- Internal clock: half-period counter, HALF=DIV/2, with DIV chosen by SC[1] sampled at start. Counter width $clog2(max DIV).
- States:
  - IDLE: wait for start.
  - LOW: O_SERIAL_CLOCK=0. Internal: after HALF cycles go to HIGH. External: on synchronised rising edge go to HIGH.
  - HIGH: entry action (rising edge) samples synchronised input: SB <= {SB[W-2:0], sin}, count++. O_SERIAL_CLOCK=1. Internal: after HALF cycles; external: on synchronised falling edge. Then if count==DATA_WIDTH go to DONE, else O_SERIAL_DATA <= SB MSB and go to LOW.
  - DONE, 1 cycle: SC[7] <= 0, O_SERIAL_INTERRUPT=1, go to IDLE.
- Internal latency: the interrupt pulse occurs exactly DATA_WIDTH*DIV+1 cycles after the start-write edge.
- External mode never times out. With no external clock the block stays busy until abort or reset.
- A simultaneous CPU SC write and DONE: the CPU write wins, and no interrupt fires if the write restarts or aborts.
- The bit counter width is $clog2(DATA_WIDTH+1) and it never wraps.

Decomposition:
- Shared package serial_pkg: state encoding (IDLE, LOW, HIGH, DONE), SC bit index constants (SC_START=7, SC_SPEED=1, SC_SRC=0), default address constants. Addresses also go into memdef.
- One sub-module, serial_sync_edge: 2-flop synchroniser with rise/fall pulse outputs, instantiated for the external clock. The data input uses the synchroniser only.
- The existing register primitive is reused for SB and SC.

Test Plan:
- Reset values: after reset, read SC -> 8'h7C, read SB -> 8'h00. O_SERIAL_CLOCK=1, O_SERIAL_INTERRUPT=0.
- Internal normal: write SB=8'hA5, SC=8'h81, I_SERIAL_DATA=1 -> O_SERIAL_DATA sequence 1,0,1,0,0,1,0,1. Each low phase lasts 256 cycles. Interrupt pulse exactly 4097 cycles after the SC write. SB reads 8'hFF, SC reads 8'h7D.
- Internal fast: SB=8'h3C, SC=8'h83, input tied 0 -> interrupt after 129 cycles, SB=8'h00, SC[7]=0.
- External: SC=8'h80, drive 8 external clocks of 20 I_CLK low/high with input pattern 8'h5A -> SB=8'h5A and one interrupt pulse. Writing SB mid-transfer leaves SB unchanged.
- Abort/restart: start internal fast, after 3 bits write SC=8'h03 -> state IDLE, clock high, no interrupt ever. Next write SC=8'h83 -> full 8-bit transfer, interrupt after 129 cycles.
- Reset mid-transfer: assert I_RESET during bit 4 -> all outputs at reset values next cycle, no interrupt pulse.
